fwd_sel_ctrl: RTL and testbench
===============================

Name: fwd_sel_ctrl

Overview:
- Produces registered 2-bit selects for the 4-to-1 operand multiplexers at the ALU inputs of the pipelined CPU.
- Tracks destination info of the three in-flight instructions (EX, MEM, WB slots) and compares it with the source registers of the instruction in ID.
- Emits a load-use stall request and keeps a saturating stall counter for performance debug.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 16, stall counter width.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- id_valid_i  input  1  ID holds a real instruction.
- id_rs_i  input  REG_AW  ID source register A.
- id_rt_i  input  REG_AW  ID source register B.
- id_use_rs_i  input  1  ID instruction reads rs.
- id_use_rt_i  input  1  ID instruction reads rt.
- id_rd_i  input  REG_AW  ID destination register, after RegDst selection.
- id_reg_write_i  input  1  ID instruction writes the register file.
- id_mem_read_i  input  1  ID instruction is a load.
- flush_i  input  1  discard the ID instruction this cycle (branch/jump taken).
- fwdA_sel_o  output  2  select for ALU operand A mux.
- fwdB_sel_o  output  2  select for ALU operand B mux.
- stall_o  output  1  hold PC and IF/ID this cycle; combinational.
- stall_cnt_o  output  CNT_W  number of stall cycles, saturating.

Behaviour:
- Select encoding, aligned with the instruction currently in EX:
  - 0 = ID/EX register-file value.
  - 1 = EX/MEM ALU result.
  - 2 = MEM/WB write-back data.
  - 3 = retired-value latch (value written to the register file at the edge after the consumer's ID read).
- Tracker: three slots ex/mem/wb, each holding valid, rd, reg_write and mem_read.
- A slot "produces r" when: valid, reg_write, rd==r and r!=0.
- stall_o = id_valid_i & !flush_i & ex slot valid & ex mem_read & ex reg_write & ex rd!=0 & ((id_use_rs_i & ex rd==id_rs_i) | (id_use_rt_i & ex rd==id_rt_i)).
- Every rising edge, no reset:
  - wb<=mem; mem<=ex.
  - ex<=ID fields if id_valid_i & !flush_i & !stall_o; otherwise ex<=bubble (valid=0).
- Select update at the same edge, computed from pre-edge slots:
  - For each operand whose use bit is set: ex slot produces src -> 1, else mem slot produces src -> 2, else wb slot produces src -> 3, else 0. Nearest producer wins.
  - An operand whose use bit is clear gets 0.
  - Bubble inserted (stall, flush or !id_valid_i) -> both selects 0.
- Load-use case: stall_o high for exactly one cycle. Next cycle the load is in the mem slot, stall_o drops, and the consumer gets select 2.
- Register 0 is never forwarded and never stalls.
- flush_i and a stall condition in the same cycle: flush wins, stall_o=0, no count.
- stall_cnt_o increments on each edge where stall_o=1; holds at all-ones (saturates, no wrap).
- Reset (asserted any time, including mid-stall): all slots invalid, fwdA_sel_o=fwdB_sel_o=0, stall_cnt_o=0. stall_o is 0 because the ex slot is invalid.
- Latency: selects are valid in the cycle after the consumer is in ID (one-edge latency). stall_o has zero latency.

Test Plan:
- Reset held, then release with idle ID -> all outputs 0; slots empty for 3 cycles; selects stay 0.
- add r3 then add r4,r3,r5 back-to-back -> fwdA_sel_o=1 in the consumer's EX cycle; fwdB_sel_o=0.
- add r3; nop; sub r6,r7,r3 -> fwdB_sel_o=2. With two nops instead -> fwdB_sel_o=3. Three nops -> 0.
- lw r8 then add r9,r8,r8 -> stall_o=1 one cycle; stall_cnt_o 0->1; consumer then gets fwdA_sel_o=fwdB_sel_o=2.
- Producers writing r3 in ex and mem slots, consumer reads r3 -> select 1 (nearest wins). Same sequence with r0 -> selects 0, no stall.
- lw r8 followed by a dependent instruction with flush_i=1 -> stall_o=0, count unchanged, selects 0. Count forced near all-ones -> saturates. rst_i pulsed low mid-stall -> immediate clear.

Source files
------------

// File: rtl/fwd_sel_ctrl_if.sv
// ID-stage to forwarding-control bus: source/destination info of the
// instruction in ID plus the registered mux selects and stall outputs.
interface fwd_sel_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid_i;
  logic [REG_AW-1:0] id_rs_i;
  logic [REG_AW-1:0] id_rt_i;
  logic              id_use_rs_i;
  logic              id_use_rt_i;
  logic [REG_AW-1:0] id_rd_i;
  logic              id_reg_write_i;
  logic              id_mem_read_i;
  logic              flush_i;
  logic [1:0]        fwdA_sel_o;
  logic [1:0]        fwdB_sel_o;
  logic              stall_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  modport master (
    output id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
           id_rd_i, id_reg_write_i, id_mem_read_i, flush_i,
    input  fwdA_sel_o, fwdB_sel_o, stall_o, stall_cnt_o
  );

  modport slave (
    input  id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
           id_rd_i, id_reg_write_i, id_mem_read_i, flush_i,
    output fwdA_sel_o, fwdB_sel_o, stall_o, stall_cnt_o
  );
endinterface

// File: rtl/fwd_sel_ctrl.sv
// Forwarding-select controller: tracks the destinations of the EX/MEM/WB
// instructions, produces registered ALU operand mux selects aligned with
// the instruction in EX, a combinational load-use stall and a saturating
// stall-cycle counter.
module fwd_sel_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  fwd_sel_ctrl_if.slave bus
);

  // Select encoding seen by the operand muxes
  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_EX  = 2'd1;
  localparam logic [1:0] SEL_MEM = 2'd2;
  localparam logic [1:0] SEL_WB  = 2'd3;

  // Tracker slots: valid bits are control (reset), the rest is data
  logic              r_ex_vld,  r_mem_vld,  r_wb_vld;
  logic [REG_AW-1:0] r_ex_rd,   r_mem_rd,   r_wb_rd;
  logic              r_ex_rw,   r_mem_rw,   r_wb_rw;
  logic              r_ex_mr,   r_mem_mr;
  logic              r_wb_mr;

  logic [1:0]        r_sel_a;
  logic [1:0]        r_sel_b;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_stall;
  logic              w_issue;
  logic [1:0]        w_sel_a;
  logic [1:0]        w_sel_b;

  // A slot produces r when it holds a valid register write to a nonzero r
  function automatic logic produces(input logic              vld,
                                    input logic              rw,
                                    input logic [REG_AW-1:0] rd,
                                    input logic [REG_AW-1:0] r);
    return vld & rw & (rd == r) & (r != '0);
  endfunction

  // Nearest producer wins: EX, then MEM, then WB, else register file
  function automatic logic [1:0] pick_sel(input logic              use_r,
                                          input logic [REG_AW-1:0] r);
    logic [1:0] sel;
    sel = SEL_RF;
    if (use_r) begin
      if (produces(r_ex_vld, r_ex_rw, r_ex_rd, r))
        sel = SEL_EX;
      else if (produces(r_mem_vld, r_mem_rw, r_mem_rd, r))
        sel = SEL_MEM;
      else if (produces(r_wb_vld, r_wb_rw, r_wb_rd, r))
        sel = SEL_WB;
    end
    return sel;
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Load in EX feeding an operand of the ID instruction; flush overrides
  always_comb begin
    w_stall = bus.id_valid_i & ~bus.flush_i &
              r_ex_vld & r_ex_mr & r_ex_rw & (r_ex_rd != '0) &
              ((bus.id_use_rs_i & (r_ex_rd == bus.id_rs_i)) |
               (bus.id_use_rt_i & (r_ex_rd == bus.id_rt_i)));
    w_issue = bus.id_valid_i & ~bus.flush_i & ~w_stall;
  end

  // Next selects from pre-edge slots; a bubble always gets register-file selects
  always_comb begin
    w_sel_a = SEL_RF;
    w_sel_b = SEL_RF;
    if (w_issue) begin
      w_sel_a = pick_sel(bus.id_use_rs_i, bus.id_rs_i);
      w_sel_b = pick_sel(bus.id_use_rt_i, bus.id_rt_i);
    end
  end

  // ---- Stage boundary ID -> EX -> MEM -> WB: control part (reset) ----
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ex_vld    <= 1'b0;
      r_mem_vld   <= 1'b0;
      r_wb_vld    <= 1'b0;
      r_sel_a     <= SEL_RF;
      r_sel_b     <= SEL_RF;
      r_stall_cnt <= '0;
    end else begin
      r_wb_vld  <= r_mem_vld;
      r_mem_vld <= r_ex_vld;
      r_ex_vld  <= w_issue;
      r_sel_a   <= w_sel_a;
      r_sel_b   <= w_sel_b;
      if (w_stall)
        r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  // ---- Stage boundary ID -> EX -> MEM -> WB: data part (no reset) ----
  always_ff @(posedge clk_i) begin
    r_wb_rd  <= r_mem_rd;
    r_wb_rw  <= r_mem_rw;
    r_wb_mr  <= r_mem_mr;
    r_mem_rd <= r_ex_rd;
    r_mem_rw <= r_ex_rw;
    r_mem_mr <= r_ex_mr;
    r_ex_rd  <= bus.id_rd_i;
    r_ex_rw  <= bus.id_reg_write_i;
    r_ex_mr  <= bus.id_mem_read_i;
  end

  assign bus.fwdA_sel_o  = r_sel_a;
  assign bus.fwdB_sel_o  = r_sel_b;
  assign bus.stall_o     = w_stall;
  assign bus.stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// Directed bench for fwd_sel_ctrl: instruction sequences driven into ID,
// selects/stall/counter compared with hand-computed values.
module tb_fwd_sel_ctrl;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 2;   // narrow counter so saturation is reachable

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  fwd_sel_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  fwd_sel_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt, input logic [4:0] rd,
                     input logic rw, input logic mr, input logic fl);
    bus.id_valid_i     = v;
    bus.id_rs_i        = rs;
    bus.id_rt_i        = rt;
    bus.id_use_rs_i    = urs;
    bus.id_use_rt_i    = urt;
    bus.id_rd_i        = rd;
    bus.id_reg_write_i = rw;
    bus.id_mem_read_i  = mr;
    bus.flush_i        = fl;
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // advance one clock, sample 1 time unit after the rising edge
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (3) cyc();
  endtask

  // common instruction shapes
  task automatic add_i(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    drv(1'b1, rs, rt, 1'b1, 1'b1, rd, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic lw_i(input logic [4:0] rd, input logic [4:0] base);
    drv(1'b1, base, 5'd0, 1'b1, 1'b0, rd, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    int exp_cnt;
    idle();

    // reset held
    repeat (2) cyc();
    chk("rst_selA", bus.fwdA_sel_o, 0);
    chk("rst_selB", bus.fwdB_sel_o, 0);
    chk("rst_stall", bus.stall_o, 0);
    chk("rst_cnt", bus.stall_cnt_o, 0);
    rst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("idle_selA", bus.fwdA_sel_o, 0);
      chk("idle_selB", bus.fwdB_sel_o, 0);
    end

    // back-to-back dependency: EX forward on operand A
    add_i(5'd3, 5'd1, 5'd2); cyc();
    add_i(5'd4, 5'd3, 5'd5); #1;
    chk("b2b_stall", bus.stall_o, 0);
    cyc();
    chk("b2b_selA", bus.fwdA_sel_o, 1);
    chk("b2b_selB", bus.fwdB_sel_o, 0);
    drain();
    chk("drain_selA", bus.fwdA_sel_o, 0);

    // distance 2, 3, 4 producer on operand B
    for (int nops = 1; nops <= 3; nops++) begin
      add_i(5'd3, 5'd1, 5'd2); cyc();
      idle();
      repeat (nops) cyc();
      add_i(5'd6, 5'd7, 5'd3); cyc();
      chk("gap_selA", bus.fwdA_sel_o, 0);
      chk("gap_selB", bus.fwdB_sel_o, (nops == 1) ? 2 : (nops == 2) ? 3 : 0);
      drain();
    end

    // load-use: one stall, then MEM forward on both operands
    lw_i(5'd8, 5'd1); cyc();
    add_i(5'd9, 5'd8, 5'd8); #1;
    chk("lu_stall", bus.stall_o, 1);
    chk("lu_cnt0", bus.stall_cnt_o, 0);
    cyc();
    chk("lu_stall_drop", bus.stall_o, 0);
    chk("lu_cnt1", bus.stall_cnt_o, 1);
    chk("lu_bub_selA", bus.fwdA_sel_o, 0);
    cyc();
    chk("lu_selA", bus.fwdA_sel_o, 2);
    chk("lu_selB", bus.fwdB_sel_o, 2);
    chk("lu_cnt_hold", bus.stall_cnt_o, 1);
    drain();

    // nearest producer wins
    add_i(5'd3, 5'd1, 5'd2); cyc();
    add_i(5'd3, 5'd1, 5'd2); cyc();
    add_i(5'd10, 5'd3, 5'd3); cyc();
    chk("near_selA", bus.fwdA_sel_o, 1);
    chk("near_selB", bus.fwdB_sel_o, 1);
    drain();

    // register 0 never forwards or stalls
    add_i(5'd0, 5'd1, 5'd2); cyc();
    lw_i(5'd0, 5'd1); cyc();
    add_i(5'd10, 5'd0, 5'd0); #1;
    chk("r0_stall", bus.stall_o, 0);
    cyc();
    chk("r0_selA", bus.fwdA_sel_o, 0);
    chk("r0_selB", bus.fwdB_sel_o, 0);
    chk("r0_cnt", bus.stall_cnt_o, 1);
    drain();

    // flush beats stall
    lw_i(5'd8, 5'd1); cyc();
    add_i(5'd9, 5'd8, 5'd8);
    bus.flush_i = 1'b1; #1;
    chk("fl_stall", bus.stall_o, 0);
    cyc();
    chk("fl_cnt", bus.stall_cnt_o, 1);
    chk("fl_selA", bus.fwdA_sel_o, 0);
    chk("fl_selB", bus.fwdB_sel_o, 0);
    drain();

    // saturation of the 2-bit counter
    exp_cnt = 1;
    for (int k = 0; k < 3; k++) begin
      lw_i(5'd8, 5'd1); cyc();
      add_i(5'd9, 5'd8, 5'd8); cyc();
      cyc();
      exp_cnt = (exp_cnt == 3) ? 3 : exp_cnt + 1;
      chk("sat_cnt", bus.stall_cnt_o, exp_cnt);
      drain();
    end

    // asynchronous reset in the middle of a stall
    add_i(5'd3, 5'd1, 5'd2); cyc();
    lw_i(5'd8, 5'd3); cyc();
    chk("mr_pre_selA", bus.fwdA_sel_o, 1);
    add_i(5'd9, 5'd8, 5'd8); #1;
    chk("mr_pre_stall", bus.stall_o, 1);
    rst_i = 1'b0; #1;
    chk("mr_stall", bus.stall_o, 0);
    chk("mr_cnt", bus.stall_cnt_o, 0);
    chk("mr_selA", bus.fwdA_sel_o, 0);
    chk("mr_selB", bus.fwdB_sel_o, 0);
    idle();
    cyc();
    rst_i = 1'b1;
    cyc();
    chk("mr_after_cnt", bus.stall_cnt_o, 0);
    chk("mr_after_selA", bus.fwdA_sel_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
